// File: rtl/twos_to_bcd_pkg.sv
// Shared definitions for the signed/unsigned byte to three-digit BCD converter.
// Holds the controller state encoding and the double-dabble constants.
package twos_to_bcd_pkg;

  // Controller states: wait for a request, iterate, publish the result
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One double-dabble iteration per input bit
  localparam logic [3:0] ITER_COUNT  = 4'd8;
  // A digit at or above this value would overflow past 9 after the next shift
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_INC    = 4'd3;

endpackage

// File: rtl/twos_to_bcd_bcd_add3.sv
// Per-digit double-dabble correction: adds 3 to a BCD digit that is 5 or more
// so that the following left shift carries correctly into the next digit.
// Ports:
//   digit     - current BCD digit
//   corrected - digit after the conditional +3
module bcd_add3
  import twos_to_bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  // Conditional +3 correction
  always_comb begin
    corrected = digit;
    if (digit >= ADD3_THRESH) begin
      corrected = digit + ADD3_INC;
    end else begin
      corrected = digit;
    end
  end

endmodule

// File: rtl/twos_to_bcd.sv
// Converts an 8-bit unsigned or two's-complement value into a sign flag and
// three BCD digits using an iterative double-dabble (one bit per cycle).
// Ports:
//   Clk, nReset        - clock and asynchronous active-low reset
//   Start, Bin, Signed - conversion request, value and signedness (captured together)
//   Busy, Done         - conversion in progress / one-cycle result-valid pulse
//   Neg                - result is negative (minus-sign digit)
//   Bcd2, Bcd1, Bcd0   - hundreds, tens and units of the magnitude
//   En2, En1, En0      - leading-zero-blanking digit enables
module twos_to_bcd
  import twos_to_bcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Bin,
  input  logic             Signed,
  output logic             Busy,
  output logic             Done,
  output logic             Neg,
  output logic [3:0]       Bcd2,
  output logic [3:0]       Bcd1,
  output logic [3:0]       Bcd0,
  output logic             En2,
  output logic             En1,
  output logic             En0
);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [3:0]         cnt_r;
  logic [WIDTH-1:0]   mag_r;
  logic [11:0]        bcd_r;
  logic               neg_r;
  logic               accept_s;
  logic               neg_in_s;
  logic [WIDTH-1:0]   mag_in_s;
  logic [11:0]        bcd_corr_s;
  logic [11+WIDTH:0]  shift_next_s;

  assign accept_s = (state_r == IDLE) && Start;
  assign neg_in_s = Signed & Bin[WIDTH-1];
  // 0x80 negates to itself, which read as unsigned is the required 128
  assign mag_in_s = neg_in_s ? (~Bin + {{(WIDTH-1){1'b0}}, 1'b1}) : Bin;

  bcd_add3 u_add3_2 (.digit(bcd_r[11:8]), .corrected(bcd_corr_s[11:8]));
  bcd_add3 u_add3_1 (.digit(bcd_r[7:4]),  .corrected(bcd_corr_s[7:4]));
  bcd_add3 u_add3_0 (.digit(bcd_r[3:0]),  .corrected(bcd_corr_s[3:0]));

  // Shift the corrected digits and the remaining magnitude bits together
  assign shift_next_s = {bcd_corr_s, mag_r} << 1'b1;

  // Controller state register
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Controller next-state logic; Start is only looked at in IDLE, so requests
  // during SHIFT or DONE are dropped rather than queued
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == (ITER_COUNT - 4'd1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Capture operands on acceptance and run the double-dabble iterations
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      mag_r <= {WIDTH{1'b0}};
      bcd_r <= 12'd0;
      cnt_r <= 4'd0;
      neg_r <= 1'b0;
    end else if (accept_s) begin
      mag_r <= mag_in_s;
      bcd_r <= 12'd0;
      cnt_r <= 4'd0;
      neg_r <= neg_in_s;
    end else if (state_r == SHIFT) begin
      {bcd_r, mag_r} <= shift_next_s;
      cnt_r          <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Registered outputs; the result is published only on the edge leaving DONE,
  // which is also the edge that raises Done
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      Busy <= 1'b0;
      Done <= 1'b0;
      Neg  <= 1'b0;
      Bcd2 <= 4'd0;
      Bcd1 <= 4'd0;
      Bcd0 <= 4'd0;
      En2  <= 1'b0;
      En1  <= 1'b0;
      En0  <= 1'b1;
    end else begin
      Busy <= (state_nxt_s != IDLE);
      Done <= (state_r == DONE);
      if (state_r == DONE) begin
        Neg  <= neg_r;
        Bcd2 <= bcd_r[11:8];
        Bcd1 <= bcd_r[7:4];
        Bcd0 <= bcd_r[3:0];
        En2  <= |bcd_r[11:8];
        En1  <= |bcd_r[11:4];
        En0  <= 1'b1;
      end else begin
        Neg  <= Neg;
      end
    end
  end

endmodule

// File: tb/tb_twos_to_bcd.sv
// Directed self-checking bench for twos_to_bcd.
module tb_twos_to_bcd;

  logic       clk;
  logic       n_reset;
  logic       start;
  logic [7:0] bin;
  logic       sgn;
  logic       busy;
  logic       done;
  logic       neg;
  logic [3:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic       en2;
  logic       en1;
  logic       en0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  twos_to_bcd #(.WIDTH(8)) dut (
    .Clk(clk), .nReset(n_reset), .Start(start), .Bin(bin), .Signed(sgn),
    .Busy(busy), .Done(done), .Neg(neg),
    .Bcd2(bcd2), .Bcd1(bcd1), .Bcd0(bcd0),
    .En2(en2), .En1(en1), .En0(en0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one request, corrupt the inputs after capture, wait (bounded) for Done
  // and compare latency and results against hand-computed values.
  task automatic run_conv(input string tag, input logic [7:0] b, input logic s,
                          input logic [11:0] exp_d, input logic exp_neg,
                          input logic [2:0] exp_en);
    int lat;
    lat   = 0;
    bin   = b;
    sgn   = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = ~b;
    sgn   = ~s;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) check({tag, "_busy"}, 32'(busy), 32'h1);
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_digits"}, 32'({bcd2, bcd1, bcd0}), 32'(exp_d));
    check({tag, "_neg"}, 32'(neg), 32'(exp_neg));
    check({tag, "_en"}, 32'({en2, en1, en0}), 32'(exp_en));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int done_cnt;
    int first_done;
    int second_done;
    logic [11:0] seen_d;
    logic        seen_busy;

    n_reset = 1'b0;
    start   = 1'b0;
    bin     = 8'h00;
    sgn     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy_done", 32'({busy, done}), 32'h0);
    check("reset_neg", 32'(neg), 32'h0);
    check("reset_digits", 32'({bcd2, bcd1, bcd0}), 32'h000);
    check("reset_en", 32'({en2, en1, en0}), 32'h1);
    n_reset = 1'b1;

    // Start is raised immediately after reset release
    run_conv("u_ff",  8'hFF, 1'b0, 12'h255, 1'b0, 3'b111);
    run_conv("s_80",  8'h80, 1'b1, 12'h128, 1'b1, 3'b111);

    // Results hold while inputs wander and no request is made
    bin = 8'h00; sgn = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("hold_digits", 32'({bcd2, bcd1, bcd0}), 32'h128);
    check("hold_neg_done", 32'({neg, done}), 32'h2);

    run_conv("s_ff",  8'hFF, 1'b1, 12'h001, 1'b1, 3'b001);
    run_conv("s_00",  8'h00, 1'b1, 12'h000, 1'b0, 3'b001);
    run_conv("u_00",  8'h00, 1'b0, 12'h000, 1'b0, 3'b001);
    run_conv("s_7f",  8'h7F, 1'b1, 12'h127, 1'b0, 3'b111);
    run_conv("s_9c",  8'h9C, 1'b1, 12'h100, 1'b1, 3'b111);
    run_conv("u_0a",  8'h0A, 1'b0, 12'h010, 1'b0, 3'b011);
    run_conv("u_80",  8'h80, 1'b0, 12'h128, 1'b0, 3'b111);

    // Requests during SHIFT and during DONE are dropped
    done_cnt  = 0;
    seen_d    = 12'hFFF;
    seen_busy = 1'b1;
    bin   = 8'h2A;
    sgn   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 8'h0A;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        seen_d = {bcd2, bcd1, bcd0};
      end
      if (c == 10) seen_busy = busy;
      if (c == 4 || c == 8) start = 1'b1;
      else start = 1'b0;
    end
    check("ignored_done_count", 32'(done_cnt), 32'd1);
    check("ignored_digits_at_done", 32'(seen_d), 32'h042);
    check("ignored_busy_after_done", 32'(seen_busy), 32'h0);
    check("ignored_digits_final", 32'({bcd2, bcd1, bcd0}), 32'h042);

    // Start held high: one conversion every 10 cycles
    first_done  = 0;
    second_done = 0;
    done_cnt    = 0;
    bin   = 8'h64;
    sgn   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 11) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) first_done = c;
        if (done_cnt == 2) second_done = c;
      end
    end
    check("b2b_first_done", 32'(first_done), 32'd9);
    check("b2b_second_done", 32'(second_done), 32'd19);
    check("b2b_done_count", 32'(done_cnt), 32'd2);
    check("b2b_digits", 32'({bcd2, bcd1, bcd0}), 32'h100);

    // Reset for one cycle in the middle of a conversion
    bin   = 8'h99;
    sgn   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_reset = 1'b0;
    #1;
    check("midrst_busy_done", 32'({busy, done}), 32'h0);
    check("midrst_neg", 32'(neg), 32'h0);
    check("midrst_digits", 32'({bcd2, bcd1, bcd0}), 32'h000);
    check("midrst_en", 32'({en2, en1, en0}), 32'h1);
    @(posedge clk); #1;
    n_reset  = 1'b1;
    done_cnt = 0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    run_conv("after_rst_07", 8'h07, 1'b0, 12'h007, 1'b0, 3'b001);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/twos_to_bcd.md
TWOS_TO_BCD -- requirements
Module: twos_to_bcd

Interface
REQ-001 Parameter: WIDTH, 8, binary input width; only WIDTH=8 is supported.
REQ-002 Clk  input  1  system clock; all state changes on its rising edge.
REQ-003 nReset  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  conversion request; sampled only while Busy=0.
REQ-005 Bin  input  8  value to convert; captured on the accepted Start edge.
REQ-006 Signed  input  1  1 = Bin is two's complement, 0 = Bin is unsigned; captured with Bin.
REQ-007 Busy  output  1  high from the accepting edge until Done has completed.
REQ-008 Done  output  1  one-cycle pulse; result outputs are valid from this cycle.
REQ-009 Neg  output  1  result is negative; drives the display's minus-sign digit.
REQ-010 Bcd2, Bcd1, Bcd0  output  4 each  hundreds, tens and units digits of the magnitude.
REQ-011 En2, En1, En0  output  1 each  leading-zero-blanking enables for the three digits.

Function
REQ-012 The block SHALL use three states: IDLE, SHIFT and DONE; Busy SHALL be 1 in every state except IDLE.
- IDLE: on a rising edge with Start=1, capture Bin and Signed and enter SHIFT with the iteration counter at 0.
- SHIFT: one double-dabble iteration per cycle, 8 cycles; on the 8th iteration enter DONE.
- DONE: assert Done for exactly one cycle, then return to IDLE.
REQ-013 Magnitude: if Signed=1 and Bin[7]=1, magnitude = (~Bin + 1), an 8-bit unsigned value; otherwise magnitude = Bin.
- Bin=0x80 with Signed=1 SHALL give magnitude 128.
REQ-014 Each SHIFT iteration SHALL first add 3 to every BCD digit that is ≥5, then shift {BCD, magnitude} left by one bit.
REQ-015 Latency: Start accepted at edge N; Done SHALL be high in the cycle after edge N+9 (exactly 9 cycles later).
REQ-016 Neg, Bcd2..0 and En2..0 SHALL update only on the edge that raises Done, and SHALL hold their values until the next Done.
REQ-017 Neg = Signed AND Bin[7]; Neg SHALL be 0 for every result equal to zero.
REQ-018 Enables: En0=1; En1 = (Bcd2≠0) OR (Bcd1≠0); En2 = (Bcd2≠0).
REQ-019 Bcd2 SHALL never exceed 2, and no digit SHALL exceed 9.
REQ-020 Start while Busy=1, including the DONE cycle, SHALL be ignored and SHALL NOT be queued.
REQ-021 Changes to Bin or Signed after capture SHALL NOT affect the conversion in progress.
REQ-022 Back-to-back operation: Start held high SHALL be accepted again on the first edge after Done falls, i.e. one conversion per 10 cycles.

Reset
REQ-023 Asserting nReset=0 SHALL immediately force: state IDLE, Busy=0, Done=0, Neg=0, Bcd2..0=0, En2=En1=0, En0=1, and clear the internal shift register and counter.
REQ-024 Reset in the middle of a conversion SHALL abort it; no Done pulse SHALL follow.
REQ-025 After nReset deasserts, the first Start SHALL be accepted normally on the next rising edge.

Structure
REQ-026 A shared package SHALL hold the state enumeration (IDLE, SHIFT, DONE), the iteration count constant (8) and the add-3 threshold constant (5).
REQ-027 A single sub-module, bcd_add3, SHALL implement the combinational per-digit correction (if ≥5 then +3); it SHALL be instantiated three times.
REQ-028 Digit outputs SHALL be registered, with no combinational path from Bin to any output.

Verification
REQ-029 Unsigned: Bin=0xFF, Signed=0, Start pulse -> Done exactly 9 cycles later; Neg=0, digits 2,5,5; En2=En1=En0=1.
REQ-030 Most negative: Bin=0x80, Signed=1 -> Neg=1, digits 1,2,8; all enables 1.
REQ-031 Leading zeros: Bin=0xFF, Signed=1 -> Neg=1, digits 0,0,1; En2=0, En1=0, En0=1.
REQ-032 Zero: Bin=0x00 with Signed=1, then with Signed=0 -> Neg=0, digits 0,0,0, En2=En1=0, both runs.
REQ-033 Ignored Start: Start for Bin=0x0A while converting 0x2A -> one Done only, digits 0,4,2; Busy low for one cycle after Done.
REQ-034 Reset mid-conversion: nReset=0 for one cycle at cycle 4 of a conversion -> no Done pulse, outputs return to reset values, next Start with Bin=0x07 gives 0,0,7.
